// File: rtl/rrf_alloc_ctrl_pkg.sv
// Shared rename-register-file constants, used by the RRF and its allocation controller.
package rrf_alloc_ctrl_pkg;

    localparam int RRF_NUM_DEFAULT = 64;
    localparam int RRF_SEL_DEFAULT = 6;

endpackage

// File: rtl/rrf_alloc_ctrl.sv
// Rename-register tag allocator: circular alloc/commit pointers with wrap bit, stall and flush rollback.
// Optional macro RRF_ALLOC_SAME_CYCLE_FREE_EN lets same-cycle commits fund same-cycle dispatch.
module rrf_alloc_ctrl
    import rrf_alloc_ctrl_pkg::*;
#(
    parameter int RRF_NUM = RRF_NUM_DEFAULT,
    parameter int RRF_SEL = RRF_SEL_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dp_req1,
    input  logic               dp_req2,
    input  logic               com_en1,
    input  logic               com_en2,
    input  logic               flush,
    input  logic [RRF_SEL:0]   flush_ptr,
    output logic [RRF_SEL-1:0] alloc_tag1,
    output logic [RRF_SEL-1:0] alloc_tag2,
    output logic [RRF_SEL:0]   alloc_ptr,
    output logic               stall,
    output logic [RRF_SEL-1:0] dpaddr1,
    output logic [RRF_SEL-1:0] dpaddr2,
    output logic               dpen1,
    output logic               dpen2,
    output logic [RRF_SEL-1:0] com_tag1,
    output logic [RRF_SEL-1:0] com_tag2,
    output logic [RRF_SEL:0]   freenum
);

    typedef logic [RRF_SEL:0]   ptr_t;
    typedef logic [RRF_SEL+1:0] avail_t;

    // The extra wrap bit makes full (difference RRF_NUM) distinct from empty (difference 0).
    function automatic ptr_t ptr_add(input ptr_t ptr, input logic [1:0] inc);
        ptr_add = ptr + ptr_t'(inc);
    endfunction

    ptr_t       alloc_ptr_q;
    ptr_t       com_ptr_q;
    ptr_t       occupancy;
    logic [1:0] need;
    logic [1:0] com_req;
    logic [1:0] com_cnt;
    avail_t     avail;
    logic       dispatch_ok;
    logic       commit_err;

    assign occupancy = alloc_ptr_q - com_ptr_q;
    assign freenum   = ptr_t'(RRF_NUM) - occupancy;
    assign need      = {1'b0, dp_req1} + {1'b0, dp_req2};
    assign com_req   = {1'b0, com_en1} + {1'b0, com_en2};

    // Retiring more than is in flight is illegal; the flag is observed in simulation, the count is clamped.
    assign commit_err = ptr_t'(com_req) > occupancy;
    assign com_cnt    = commit_err ? occupancy[1:0] : com_req;

`ifdef RRF_ALLOC_SAME_CYCLE_FREE_EN
    assign avail = avail_t'(freenum) + avail_t'(com_cnt);
`else
    assign avail = avail_t'(freenum);
`endif

    assign stall       = avail_t'(need) > avail;
    assign dispatch_ok = !stall && !flush && !reset;

    assign alloc_ptr  = alloc_ptr_q;
    assign alloc_tag1 = alloc_ptr_q[RRF_SEL-1:0];
    assign alloc_tag2 = alloc_tag1 + 1'b1;
    assign com_tag1   = com_ptr_q[RRF_SEL-1:0];
    assign com_tag2   = com_tag1 + 1'b1;
    assign dpaddr1    = alloc_tag1;
    assign dpaddr2    = alloc_tag2;
    assign dpen1      = dp_req1 && dispatch_ok;
    assign dpen2      = dp_req2 && dispatch_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr_q <= '0;
            com_ptr_q   <= '0;
        end else begin
            if (flush) begin
                alloc_ptr_q <= flush_ptr;
            end else if (dispatch_ok) begin
                alloc_ptr_q <= ptr_add(alloc_ptr_q, need);
            end
            com_ptr_q <= ptr_add(com_ptr_q, com_cnt);
        end
    end

endmodule
